rr_mux: RTL and testbench



---
 rtl/rr_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/rr_mux.sv | 117 +++++++++++
 tb/tb_rr_mux.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the round-robin output mux.
package rr_mux_pkg;

   localparam int RR_MUX_WIDTH    = 5;
   localparam int RR_MUX_CHANNELS = 4;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority search: first requester at or after ptr,
// wrapping past the last channel.
module rr_arbiter
   import rr_mux_pkg::*;
#(
   parameter int N     = RR_MUX_CHANNELS,
   parameter int SEL_W = clog2_min1(RR_MUX_CHANNELS)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             gnt_any
);

   localparam logic [SEL_W:0] N_W = (SEL_W + 1)'(N);

   logic [2*N-1:0]   req_dbl;
   logic [2*N-1:0]   req_rot_full;
   logic [N-1:0]     req_rot;
   logic [SEL_W-1:0] gnt_off;
   logic [SEL_W:0]   gnt_sum;

   // Bit k of req_rot is the request of channel (ptr + k) mod N.
   assign req_dbl      = {req, req};
   assign req_rot_full = req_dbl >> ptr;
   assign req_rot      = req_rot_full[N-1:0];

   always_comb begin
      gnt_off = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            gnt_off = SEL_W'(k);
         end
      end
   end

   always_comb begin
      gnt_sum = {1'b0, ptr} + {1'b0, gnt_off};
      if (gnt_sum >= N_W) begin
         gnt_sum = gnt_sum - N_W;
      end
   end

   assign gnt_idx = gnt_sum[SEL_W-1:0];
   assign gnt_any = |req;

endmodule

// File: rtl/rr_mux.sv
// Round-robin N:1 mux with a single registered output slot.
// Optional registered parity output enabled by macro RR_MUX_PARITY_EN.
module rr_mux
   import rr_mux_pkg::*;
#(
   parameter  int WIDTH    = RR_MUX_WIDTH,
   parameter  int CHANNELS = RR_MUX_CHANNELS,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
`ifdef RR_MUX_PARITY_EN
   output logic                      out_par,
`endif
   input  logic                      out_ready
);

   logic [WIDTH-1:0] chan_data [CHANNELS];
   logic [SEL_W-1:0] gnt_idx;
   logic             gnt_any;
   logic             load;
   logic [SEL_W-1:0] ptr_inc;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SEL_W-1:0] out_sel_q,   out_sel_d;
   logic [SEL_W-1:0] ptr_q,       ptr_d;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
         assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   rr_arbiter #(
      .N     (CHANNELS),
      .SEL_W (SEL_W)
   ) u_arb (
      .req     (in_valid),
      .ptr     (ptr_q),
      .gnt_idx (gnt_idx),
      .gnt_any (gnt_any)
   );

   // Gating with rst_n keeps in_ready low while reset is held.
   assign load = rst_n & (~out_valid_q | out_ready) & gnt_any;

   assign ptr_inc = (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + SEL_W'(1);

   always_comb begin
      in_ready = '0;
      if (load) begin
         in_ready[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = chan_data[gnt_idx];
         out_sel_d   = gnt_idx;
         ptr_d       = ptr_inc;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

`ifdef RR_MUX_PARITY_EN
   logic out_par_q, out_par_d;

   always_comb begin
      out_par_d = out_par_q;
      if (load) begin
         out_par_d = ^chan_data[gnt_idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_par_q <= 1'b0;
      end else begin
         out_par_q <= out_par_d;
      end
   end

   assign out_par = out_par_q;
`endif

endmodule

// File: tb/tb_rr_mux.sv
// Scoreboard bench for rr_mux: stimulus task predicts each loaded word from a
// round-robin reference model; a negedge monitor checks every output transfer.
module tb_rr_mux;

   localparam int W = 5;
   localparam int C = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [C-1:0]     in_valid = '0;
   logic [C*W-1:0]   in_data = '0;
   logic [C-1:0]     in_ready;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic [1:0]       out_sel;
   logic             out_ready = 1'b0;
`ifdef RR_MUX_PARITY_EN
   logic             out_par;
`endif

   always #5 clk = ~clk;

   rr_mux #(.WIDTH(W), .CHANNELS(C)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
`ifdef RR_MUX_PARITY_EN
      .out_par   (out_par),
`endif
      .out_ready (out_ready)
   );

   typedef struct {
      logic [W-1:0] data;
      int           sel;
      logic         par;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   m_ptr = 0;
   bit   m_hold = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus plus the reference model's view of that cycle.
   task automatic step(input logic [C-1:0] v, input logic [C*W-1:0] d, input logic rdy);
      int           g;
      int           idx;
      bit           ld;
      logic [C-1:0] er;
      exp_t         e;
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      chk("out_valid", 32'(out_valid), 32'(m_hold));
      ld = (!m_hold || rdy) && (v != '0);
      g  = -1;
      er = '0;
      if (ld) begin
         for (int k = 0; k < C; k++) begin
            idx = (m_ptr + k) % C;
            if (g < 0 && v[idx]) g = idx;
         end
         e.data = d[g*W +: W];
         e.sel  = g;
         e.par  = ^e.data;
         sb_q.push_back(e);
         m_ptr  = (g + 1) % C;
         m_hold = 1'b1;
         er[g]  = 1'b1;
      end else if (rdy) begin
         m_hold = 1'b0;
      end
      #1;
      chk("in_ready", 32'(in_ready), 32'(er));
   endtask

   // Asynchronous reset with random inputs, released with requests idle.
   task automatic do_reset();
      #1;
      in_valid  = C'($urandom);
      in_data   = (C*W)'($urandom);
      out_ready = 1'($urandom);
      rst_n     = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sel", 32'(out_sel), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef RR_MUX_PARITY_EN
      chk("rst_out_par", 32'(out_par), 32'd0);
`endif
      sb_q.delete();
      m_hold = 1'b0;
      m_ptr  = 0;
      @(posedge clk);
      #1;
      chk("rst_hold_valid", 32'(out_valid), 32'd0);
      chk("rst_hold_ready", 32'(in_ready), 32'd0);
      in_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every output transfer must match the oldest predicted word.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got sel=%0d data=%0h expected none", out_sel, out_data);
            end else begin
               mon_e = sb_q.pop_front();
               chk("out_data", 32'(out_data), 32'(mon_e.data));
               chk("out_sel", 32'(out_sel), 32'(mon_e.sel));
`ifdef RR_MUX_PARITY_EN
               chk("out_par", 32'(out_par), 32'(mon_e.par));
`endif
               $display("xfer sel=%0d data=%0h", out_sel, out_data);
            end
         end
      end
   end

   initial begin
      logic [C*W-1:0] idx_data;
      idx_data = {5'd3, 5'd2, 5'd1, 5'd0};

      @(negedge clk);
      do_reset();

      // All channels requesting: strict rotation, one word per cycle.
      for (int n = 0; n < 8; n++) step(4'hF, idx_data, 1'b1);
      step('0, '0, 1'b1);
      step('0, '0, 1'b1);

      // Backpressure on a single channel, then drain.
      step(4'b0100, (C*W)'(5'h15) << (2*W), 1'b0);
      for (int n = 0; n < 3; n++) step(4'b0100, (C*W)'(5'h15) << (2*W), 1'b0);
      step('0, '0, 1'b1);
      step('0, '0, 1'b1);

      // Pointer now sits at 3: wrap to channel 0, then channel 1.
      step(4'b0011, idx_data, 1'b1);
      step(4'b0011, idx_data, 1'b1);
      step('0, '0, 1'b1);

      // Reset while a word is held under backpressure.
      step(4'b0100, idx_data, 1'b0);
      step(4'b0100, idx_data, 1'b0);
      do_reset();
      step(4'hF, idx_data, 1'b1);
      step('0, '0, 1'b1);

      // Parity patterns on channel 0.
      step(4'b0001, (C*W)'(5'b10110), 1'b1);
      step(4'b0001, (C*W)'(5'b00011), 1'b1);
      step('0, '0, 1'b1);

      for (int n = 0; n < 400; n++) begin
         step(C'($urandom), (C*W)'($urandom), ($urandom_range(0, 3) != 0));
         if (n == 200) do_reset();
      end

      step('0, '0, 1'b1);
      step('0, '0, 1'b1);
      @(negedge clk);
      #1;
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
